// File: rtl/sc_serializer_verify.sv
// Slow-control serializer: shifts a latched configuration word onto D_SC with ss framing and
// optionally re-shifts it while comparing the ASIC readback on Q_SC against the sent bits.
module sc_serializer_verify #(
  parameter int unsigned SC_WIDTH  = 829,
  parameter int unsigned LSB_FIRST = 1,
  parameter int unsigned IDX_W     = 10,
  parameter int unsigned ERR_W     = 10
) (
  input  logic                CK_SC,
  input  logic                rst,
  input  logic                start,
  input  logic                verify,
  input  logic [SC_WIDTH-1:0] sc_data,
  input  logic                Q_SC,
  output logic                D_SC,
  output logic                ss,
  output logic                busy,
  output logic                done,
  output logic                match,
  output logic [ERR_W-1:0]    err_cnt
);

  typedef enum logic [1:0] {StIdle, StShift, StVerify, StDone} state_e;

  localparam logic [IDX_W-1:0] IdxLast = IDX_W'(SC_WIDTH - 1);
  localparam logic [ERR_W-1:0] ErrMax  = {ERR_W{1'b1}};

  state_e              state_q, state_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [SC_WIDTH-1:0] shadow_q, shadow_d;
  logic                mode_q, mode_d;
  logic                d_sc_q, d_sc_d;
  logic                ss_q, ss_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                match_q, match_d;
  logic [ERR_W-1:0]    err_q, err_d;
  logic [ERR_W-1:0]    err_next;

  // The shadow word is rotated one step per transmitted bit, so the next bit to send is always
  // at the head; after SC_WIDTH rotations it is back in its latched order for the verify pass.
  function automatic logic head(input logic [SC_WIDTH-1:0] w);
    if (LSB_FIRST != 0) return w[0];
    else return w[SC_WIDTH-1];
  endfunction

  function automatic logic [SC_WIDTH-1:0] rot(input logic [SC_WIDTH-1:0] w);
    if (LSB_FIRST != 0) return {w[0], w[SC_WIDTH-1:1]};
    else return {w[SC_WIDTH-2:0], w[SC_WIDTH-1]};
  endfunction

  // Readback compare against the bit currently driven; counter saturates at all-ones.
  always_comb begin
    err_next = err_q;
    if ((Q_SC != d_sc_q) && (err_q != ErrMax)) err_next = err_q + ERR_W'(1);
  end

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    shadow_d = shadow_q;
    mode_d   = mode_q;
    d_sc_d   = d_sc_q;
    ss_d     = ss_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    match_d  = match_q;
    err_d    = err_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          shadow_d = rot(sc_data);
          mode_d   = verify;
          err_d    = '0;
          match_d  = 1'b0;
          idx_d    = '0;
          d_sc_d   = head(sc_data);
          ss_d     = 1'b1;
          busy_d   = 1'b1;
          state_d  = StShift;
        end
      end
      StShift: begin
        if (idx_q == IdxLast) begin
          idx_d = '0;
          if (mode_q) begin
            d_sc_d   = head(shadow_q);
            shadow_d = rot(shadow_q);
            state_d  = StVerify;
          end else begin
            d_sc_d  = 1'b0;
            ss_d    = 1'b0;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = StDone;
          end
        end else begin
          idx_d    = idx_q + IDX_W'(1);
          d_sc_d   = head(shadow_q);
          shadow_d = rot(shadow_q);
        end
      end
      StVerify: begin
        err_d = err_next;
        if (idx_q == IdxLast) begin
          idx_d   = '0;
          d_sc_d  = 1'b0;
          ss_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          match_d = (err_next == '0);
          state_d = StDone;
        end else begin
          idx_d    = idx_q + IDX_W'(1);
          d_sc_d   = head(shadow_q);
          shadow_d = rot(shadow_q);
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge CK_SC) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      mode_q  <= 1'b0;
      d_sc_q  <= 1'b0;
      ss_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      d_sc_q  <= d_sc_d;
      ss_q    <= ss_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      match_q <= match_d;
      err_q   <= err_d;
    end
  end

  // Datapath register: only meaningful after a start is accepted.
  always_ff @(posedge CK_SC) begin
    shadow_q <= shadow_d;
  end

  assign D_SC    = d_sc_q;
  assign ss      = ss_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign match   = match_q;
  assign err_cnt = err_q;

endmodule
